// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - word handshake between user logic and the UART transmitter FIFO
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] din_data;
    logic                 din_vld;
    logic                 din_rdy;

    modport master (output din_data, output din_vld, input din_rdy);
    modport slave  (input din_data, input din_vld, output din_rdy);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter fed by a small word FIFO
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 bus,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        baud_cnt, baud_n;
    logic [2:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 push, pop, tick, line_n;

    // Full is judged on the registered count, so a pop in the same cycle never frees a slot early.
    assign bus.din_rdy = (fifo_cnt != CNT_FULL);
    assign push        = bus.din_vld && bus.din_rdy;
    assign tick        = (baud_cnt == BAUD_LAST);

    // Next-state, baud/bit counters, pop request and the line level for the current state.
    always_comb begin
        state_n = state;
        baud_n  = tick ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        pop     = 1'b0;
        line_n  = 1'b1;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                line_n = 1'b0;
                if (tick) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                line_n = shreg[bit_cnt];
                if (tick) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            PAR: begin
                line_n = par_bit;
                if (tick) begin
                    state_n = STOP;
                    bit_n   = '0;
                end
            end
            STOP: begin
                line_n = 1'b1;
                if (tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_n = '0;
                        if (fifo_cnt != '0) begin
                            pop     = 1'b1;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
        end
    end

    // FIFO storage; contents need no reset since the count says what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din_data;
        end
    end

    // FIFO pointers, occupancy, and latching the popped word plus its parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                shreg   <= mem[rd_ptr];
                par_bit <= (PARITY == 2) ? ^mem[rd_ptr] : ~^mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Registered line and busy, one cycle behind the state so every bit lasts exactly DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 1'b1;
            busy <= 1'b0;
        end else begin
            dout <= line_n;
            busy <= (state != IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo over four parameter sets
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         sel = 0;
    logic [7:0] data = '0;
    logic       vld = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_b ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_c ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if_d ();

    logic       dout_a, dout_b, dout_c, dout_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;

    assign if_a.din_data = data;
    assign if_b.din_data = data;
    assign if_c.din_data = data;
    assign if_d.din_data = data[6:0];
    assign if_a.din_vld  = vld && (sel == 0);
    assign if_b.din_vld  = vld && (sel == 1);
    assign if_c.din_vld  = vld && (sel == 2);
    assign if_d.din_vld  = vld && (sel == 3);

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_a (.clk(clk), .rst(rst), .bus(if_a), .dout(dout_a), .busy(busy_a), .fifo_cnt(cnt_a));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_b (.clk(clk), .rst(rst), .bus(if_b), .dout(dout_b), .busy(busy_b), .fifo_cnt(cnt_b));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_c (.clk(clk), .rst(rst), .bus(if_c), .dout(dout_c), .busy(busy_c), .fifo_cnt(cnt_c));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_d (.clk(clk), .rst(rst), .bus(if_d), .dout(dout_d), .busy(busy_d), .fifo_cnt(cnt_d));

    logic       dout_m, busy_m, rdy_m;
    logic [2:0] cnt_m;

    always_comb begin
        dout_m = dout_a; busy_m = busy_a; rdy_m = if_a.din_rdy; cnt_m = cnt_a;
        case (sel)
            1: begin dout_m = dout_b; busy_m = busy_b; rdy_m = if_b.din_rdy; cnt_m = cnt_b; end
            2: begin dout_m = dout_c; busy_m = busy_c; rdy_m = if_c.din_rdy; cnt_m = cnt_c; end
            3: begin dout_m = dout_d; busy_m = busy_d; rdy_m = if_d.din_rdy; cnt_m = cnt_d; end
            default: ;
        endcase
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         push_cyc = 0;
    int         busy_cnt = 0;
    int         cnt_peak = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy_m === 1'b1) busy_cnt = busy_cnt + 1;
        if (int'(cnt_m) > cnt_peak) cnt_peak = int'(cnt_m);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int nbits(input int s);
        case (s)
            0:       return 10;
            1, 2:    return 11;
            default: return 11;
        endcase
    endfunction

    // Reference frame, index 0 = start bit; unused upper positions stay 1.
    function automatic logic [15:0] exp_frame(input logic [7:0] w, input int s);
        logic [15:0] v;
        logic        p;
        int          db, pr;
        v = '1;
        p = 1'b0;
        case (s)
            0:       begin db = 8; pr = 0; end
            1:       begin db = 8; pr = 2; end
            2:       begin db = 8; pr = 1; end
            default: begin db = 7; pr = 1; end
        endcase
        v[0] = 1'b0;
        for (int i = 0; i < db; i++) begin
            v[1 + i] = w[i];
            p = p ^ w[i];
        end
        if (pr != 0) v[1 + db] = (pr == 2) ? p : ~p;
        return v;
    endfunction

    task automatic push_word(input logic [7:0] w, output bit acc);
        @(negedge clk);
        data = w;
        vld  = 1'b1;
        acc  = (rdy_m === 1'b1);
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q.push_back(w);
            push_cyc = cyc;
        end
        vld = 1'b0;
    endtask

    // Waits for a start bit, then samples every cycle of nb bits of DIV=10 cycles.
    task automatic capture(input int nb, output logic [15:0] bits, output int bad,
                           output int t0, output int t_end, output bit to);
        int w;
        logic first;
        w = 0; to = 1'b0; bad = 0; bits = '1; t0 = 0; t_end = 0;
        @(negedge clk);
        while (dout_m !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            to = 1'b1;
            return;
        end
        t0 = cyc;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < 10; j++) begin
                if (i != 0 || j != 0) @(negedge clk);
                if (j == 0) first = dout_m;
                if (dout_m !== first) bad++;
                if (j == 5) bits[i] = dout_m;
            end
        end
        t_end = cyc;
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 5) rst = 1'b0;
            n_cmp++;
            if ({dout_m, busy_m, rdy_m, cnt_m} !== 6'b101_000) begin
                n_bad++;
                $display("FAIL reset_state cycle %0d: got dout=%b busy=%b rdy=%b cnt=%0d, want 1 0 1 0",
                         i, dout_m, busy_m, rdy_m, cnt_m);
            end
        end
    endtask

    task automatic test_8n1();
        bit acc;
        logic [15:0] bits, exp;
        logic [15:0] mask;
        int bad, t0, te;
        bit to;
        sel = 0;
        busy_cnt = 0;
        push_word(8'h55, acc);
        capture(10, bits, bad, t0, te, to);
        mask = 16'h03FF;
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL 8n1_timeout: no start bit seen"); end
        else begin
            exp = exp_frame(exp_q.pop_front(), 0);
            n_cmp++;
            if ((bits & mask) !== (exp & mask)) begin
                n_bad++; $display("FAIL 8n1_bits: got %h want %h", bits & mask, exp & mask);
            end
            n_cmp++;
            if ((bits & mask) !== 16'h02AA) begin
                n_bad++; $display("FAIL 8n1_pattern: got %h want 02aa", bits & mask);
            end
            n_cmp++;
            if (t0 != push_cyc + 2) begin
                n_bad++; $display("FAIL 8n1_latency: start at edge %0d want %0d", t0, push_cyc + 2);
            end
            n_cmp++;
            if (bad != 0) begin
                n_bad++; $display("FAIL 8n1_bit_width: %0d unstable cycles, want 0", bad);
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy_cnt != 100) begin
            n_bad++; $display("FAIL 8n1_busy_len: got %0d want 100", busy_cnt);
        end
        n_cmp++;
        if ({dout_m, busy_m, cnt_m} !== 5'b10_000) begin
            n_bad++; $display("FAIL 8n1_idle: got dout=%b busy=%b cnt=%0d want 1 0 0", dout_m, busy_m, cnt_m);
        end
    endtask

    task automatic frame_check(input int s, input logic [7:0] w, input logic [10:0] literal, input string nm);
        bit acc, to;
        logic [15:0] bits, exp;
        int bad, t0, te;
        logic b_end;
        sel = s;
        push_word(w, acc);
        capture(nbits(s), bits, bad, t0, te, to);
        b_end = busy_m;
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL %s_timeout: no start bit seen", nm); return; end
        exp = exp_frame(exp_q.pop_front(), s);
        n_cmp++;
        if (bits[10:0] !== exp[10:0]) begin
            n_bad++; $display("FAIL %s_bits: got %b want %b", nm, bits[10:0], exp[10:0]);
        end
        n_cmp++;
        if (bits[10:0] !== literal) begin
            n_bad++; $display("FAIL %s_literal: got %b want %b", nm, bits[10:0], literal);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL %s_bit_width: %0d unstable cycles, want 0", nm, bad);
        end
        @(negedge clk);
        n_cmp++;
        if ({b_end, busy_m, dout_m} !== 3'b101) begin
            n_bad++; $display("FAIL %s_frame_len: busy end/next=%b%b dout=%b want 1 0 1", nm, b_end, busy_m, dout_m);
        end
    endtask

    task automatic test_parity();
        frame_check(1, 8'h07, 11'b11_0000_0111_0, "even_par");
        repeat (3) @(negedge clk);
        frame_check(2, 8'h07, 11'b10_0000_0111_0, "odd_par");
    endtask

    task automatic test_back_to_back();
        int first_rej;
        sel = 0;
        cnt_peak = 0;
        first_rej = 0;
        fork
            begin
                bit acc;
                int tries;
                for (int w = 1; w <= 6; w++) begin
                    tries = 0;
                    do begin
                        push_word(w[7:0], acc);
                        if (!acc && first_rej == 0) first_rej = w;
                        tries++;
                    end while (!acc && tries < 500);
                end
            end
            begin
                logic [15:0] bits, exp;
                int bad, t0, te, prev_end;
                bit to;
                prev_end = 0;
                for (int k = 0; k < 6; k++) begin
                    capture(10, bits, bad, t0, te, to);
                    n_cmp++;
                    if (to || exp_q.size() == 0) begin
                        n_bad++; $display("FAIL b2b_frame%0d: timeout=%0d queue=%0d", k, to, exp_q.size());
                        break;
                    end
                    exp = exp_frame(exp_q.pop_front(), 0);
                    n_cmp++;
                    if (bits[9:0] !== exp[9:0] || bad != 0) begin
                        n_bad++; $display("FAIL b2b_bits%0d: got %b want %b unstable=%0d", k, bits[9:0], exp[9:0], bad);
                    end
                    if (k > 0) begin
                        n_cmp++;
                        if (t0 != prev_end + 1) begin
                            n_bad++; $display("FAIL b2b_gap%0d: start %0d want %0d", k, t0, prev_end + 1);
                        end
                    end
                    prev_end = te;
                end
            end
        join
        n_cmp++;
        if (first_rej != 6) begin
            n_bad++; $display("FAIL b2b_first_reject: got word %0d want 6", first_rej);
        end
        n_cmp++;
        if (cnt_peak != 4) begin
            n_bad++; $display("FAIL b2b_cnt_peak: got %0d want 4", cnt_peak);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        int w, lows;
        sel = 0;
        push_word(8'h00, acc);
        push_word(8'h11, acc);
        push_word(8'h22, acc);
        w = 0;
        @(negedge clk);
        while (dout_m !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        n_cmp++;
        if (w >= 100) begin n_bad++; $display("FAIL rstmid_timeout: no start bit seen"); end
        repeat (34) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dout_m, busy_m, rdy_m, cnt_m} !== 6'b101_000) begin
            n_bad++; $display("FAIL rstmid_async: got dout=%b busy=%b rdy=%b cnt=%0d want 1 0 1 0",
                              dout_m, busy_m, rdy_m, cnt_m);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (dout_m !== 1'b1 || busy_m !== 1'b0) lows++;
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++; $display("FAIL rstmid_resend: %0d active cycles after release, want 0", lows);
        end
    endtask

    task automatic test_data7();
        frame_check(3, 8'h7F, 11'b11_0_1111111_0, "d7o2");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_data7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
